// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline: load-use
// bubbles, taken-branch flushes, memory-busy freeze and saturating statistics.
module pipeline_hazard_ctrl #(
  parameter int unsigned LU_STALLS = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_idex_memRead,
  input  logic [4:0]       i_idex_rt,
  input  logic [4:0]       i_ifid_rs,
  input  logic [4:0]       i_ifid_rt,
  input  logic             i_ifid_uses_rt,
  input  logic             i_exmem_branch,
  input  logic             i_exmem_zero,
  input  logic             i_mem_busy,
  output logic             o_pc_write,
  output logic             o_pc_src,
  output logic             o_ifid_write,
  output logic             o_idex_write,
  output logic             o_exmem_write,
  output logic             o_memwb_write,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_exmem_flush,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam logic [0:0]       ST_RUN      = 1'b0;
  localparam logic [0:0]       ST_LU_STALL = 1'b1;
  localparam logic [3:0]       REM_LOAD    = 4'(LU_STALLS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [3:0]       r_rem;
  logic [3:0]       w_rem_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic             w_hazard;
  logic             w_taken;

  // A load into $zero never produces a value a consumer could wait for.
  function automatic logic load_use(
    input logic       mem_read,
    input logic [4:0] idex_rt,
    input logic [4:0] ifid_rs,
    input logic [4:0] ifid_rt,
    input logic       uses_rt
  );
    return mem_read && (idex_rt != 5'd0) &&
           ((idex_rt == ifid_rs) || (uses_rt && (idex_rt == ifid_rt)));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] cnt,
    input logic             inc
  );
    if (inc && (cnt != CNT_MAX)) begin
      return cnt + CNT_ONE;
    end else begin
      return cnt;
    end
  endfunction

  assign w_hazard = load_use(i_idex_memRead, i_idex_rt, i_ifid_rs, i_ifid_rt, i_ifid_uses_rt);
  assign w_taken  = i_exmem_branch & i_exmem_zero;

  // Next-state, counter increments and all buffer enables/flushes.
  always_comb begin
    w_state_nxt   = r_state;
    w_rem_nxt     = r_rem;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    o_pc_write    = 1'b1;
    o_pc_src      = 1'b0;
    o_ifid_write  = 1'b1;
    o_idex_write  = 1'b1;
    o_exmem_write = 1'b1;
    o_memwb_write = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_flush  = 1'b0;
    o_exmem_flush = 1'b0;
    if (rst) begin
      o_pc_write    = 1'b0;
      o_ifid_write  = 1'b0;
      o_idex_write  = 1'b0;
      o_exmem_write = 1'b0;
      o_memwb_write = 1'b0;
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_exmem_flush = 1'b1;
    end else if (i_mem_busy) begin
      o_pc_write    = 1'b0;
      o_ifid_write  = 1'b0;
      o_idex_write  = 1'b0;
      o_exmem_write = 1'b0;
      o_memwb_write = 1'b0;
    end else if (w_taken) begin
      o_pc_src      = 1'b1;
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_exmem_flush = 1'b1;
      w_flush_inc   = 1'b1;
      w_state_nxt   = ST_RUN;
      w_rem_nxt     = 4'd0;
    end else begin
      case (r_state)
        ST_LU_STALL: begin
          o_pc_write   = 1'b0;
          o_ifid_write = 1'b0;
          o_idex_flush = 1'b1;
          w_stall_inc  = 1'b1;
          if (r_rem <= 4'd1) begin
            w_state_nxt = ST_RUN;
            w_rem_nxt   = 4'd0;
          end else begin
            w_rem_nxt   = r_rem - 4'd1;
          end
        end
        ST_RUN: begin
          if (w_hazard) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_idex_flush = 1'b1;
            w_stall_inc  = 1'b1;
            if (LU_STALLS > 32'd1) begin
              w_state_nxt = ST_LU_STALL;
              w_rem_nxt   = REM_LOAD;
            end else begin
              w_state_nxt = ST_RUN;
              w_rem_nxt   = 4'd0;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_rem_nxt   = 4'd0;
        end
      endcase
    end
  end

  // State, bubble down-counter and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_rem       <= 4'd0;
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_rem       <= w_rem_nxt;
      r_stall_cnt <= sat_inc(r_stall_cnt, w_stall_inc);
      r_flush_cnt <= sat_inc(r_flush_cnt, w_flush_inc);
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: table-driven vectors with a
// scoreboard on a LU_STALLS=1 instance, hand sequences on a LU_STALLS=3 one.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       mr;
    logic [4:0] idex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       br;
    logic       zero;
    logic       busy;
  } in_t;

  typedef struct {
    in_t         in;
    logic [8:0]  out;
    logic [15:0] st;
    logic [15:0] fl;
  } vec_t;

  typedef struct {
    logic [8:0]  out;
    logic [15:0] st;
    logic [15:0] fl;
    int          id;
  } exp_t;

  // {pc_write, pc_src, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, exmem_f}
  localparam logic [8:0] O_NORM  = 9'b101111000;
  localparam logic [8:0] O_STALL = 9'b000111010;
  localparam logic [8:0] O_TAKEN = 9'b111111111;
  localparam logic [8:0] O_BUSY  = 9'b000000000;
  localparam logic [8:0] O_RST   = 9'b000000111;

  logic clk = 1'b0;
  logic rst1, rst3;
  in_t  in1, in3;
  logic [8:0]  o1, o3;
  logic [15:0] st1, fl1, st3, fl3;
  int n_checks = 0;
  int n_fail = 0;
  vec_t tbl[16];
  exp_t q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LU_STALLS(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst1),
    .i_idex_memRead(in1.mr), .i_idex_rt(in1.idex_rt), .i_ifid_rs(in1.rs),
    .i_ifid_rt(in1.rt), .i_ifid_uses_rt(in1.uses), .i_exmem_branch(in1.br),
    .i_exmem_zero(in1.zero), .i_mem_busy(in1.busy),
    .o_pc_write(o1[8]), .o_pc_src(o1[7]), .o_ifid_write(o1[6]), .o_idex_write(o1[5]),
    .o_exmem_write(o1[4]), .o_memwb_write(o1[3]), .o_ifid_flush(o1[2]),
    .o_idex_flush(o1[1]), .o_exmem_flush(o1[0]),
    .o_stall_cnt(st1), .o_flush_cnt(fl1)
  );

  pipeline_hazard_ctrl #(.LU_STALLS(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst3),
    .i_idex_memRead(in3.mr), .i_idex_rt(in3.idex_rt), .i_ifid_rs(in3.rs),
    .i_ifid_rt(in3.rt), .i_ifid_uses_rt(in3.uses), .i_exmem_branch(in3.br),
    .i_exmem_zero(in3.zero), .i_mem_busy(in3.busy),
    .o_pc_write(o3[8]), .o_pc_src(o3[7]), .o_ifid_write(o3[6]), .o_idex_write(o3[5]),
    .o_exmem_write(o3[4]), .o_memwb_write(o3[3]), .o_ifid_flush(o3[2]),
    .o_idex_flush(o3[1]), .o_exmem_flush(o3[0]),
    .o_stall_cnt(st3), .o_flush_cnt(fl3)
  );

  function automatic in_t mk(input logic mr, input logic [4:0] idex_rt, input logic [4:0] rs,
                             input logic [4:0] rt, input logic uses, input logic br,
                             input logic zero, input logic busy);
    in_t v;
    v.mr = mr; v.idex_rt = idex_rt; v.rs = rs; v.rt = rt;
    v.uses = uses; v.br = br; v.zero = zero; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step3(input in_t v, input logic [8:0] eo, input string nm);
    @(negedge clk);
    in3 = v;
    #1 chk(nm, 32'(o3), 32'(eo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_t idle, haz, tk, tk_haz;
    exp_t e;
    idle   = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    haz    = mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tk     = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tk_haz = mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    tbl[0]  = '{idle, O_NORM, 16'd0, 16'd0};
    tbl[1]  = '{haz, O_STALL, 16'd1, 16'd0};
    tbl[2]  = '{idle, O_NORM, 16'd1, 16'd0};
    tbl[3]  = '{mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), O_NORM, 16'd1, 16'd0};
    tbl[4]  = '{mk(1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0), O_NORM, 16'd1, 16'd0};
    tbl[5]  = '{mk(1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0), O_STALL, 16'd2, 16'd0};
    tbl[6]  = '{mk(1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0), O_NORM, 16'd2, 16'd0};
    tbl[7]  = '{tk_haz, O_TAKEN, 16'd2, 16'd1};
    tbl[8]  = '{mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), O_NORM, 16'd2, 16'd1};
    for (int i = 9; i < 13; i++) begin
      tbl[i] = '{mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1), O_BUSY, 16'd2, 16'd1};
    end
    tbl[13] = '{tk, O_TAKEN, 16'd2, 16'd2};
    tbl[14] = '{mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1), O_BUSY, 16'd2, 16'd2};
    tbl[15] = '{idle, O_NORM, 16'd2, 16'd2};

    rst1 = 1'b1; rst3 = 1'b1; in1 = idle; in3 = idle;
    #3;
    chk("rst_out1", 32'(o1), 32'(O_RST));
    chk("rst_out3", 32'(o3), 32'(O_RST));
    chk("rst_st1", 32'(st1), 32'd0);
    chk("rst_fl1", 32'(fl1), 32'd0);
    @(negedge clk); @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in1 = tbl[i].in;
      q.push_back('{tbl[i].out, tbl[i].st, tbl[i].fl, i});
      #1 chk($sformatf("vec%0d_out", i), 32'(o1), 32'(q[0].out));
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk($sformatf("vec%0d_stall", e.id), 32'(st1), 32'(e.st));
      chk($sformatf("vec%0d_flush", e.id), 32'(fl1), 32'(e.fl));
    end

    // LU_STALLS=3: branch beats hazard, then exactly three bubbles.
    step3(tk_haz, O_TAKEN, "lu3_taken_haz");
    step3(idle, O_NORM, "lu3_after_taken");
    chk("lu3_st0", 32'(st3), 32'd0);
    chk("lu3_fl1", 32'(fl3), 32'd1);
    step3(haz, O_STALL, "lu3_bub1");
    step3(idle, O_STALL, "lu3_bub2");
    step3(idle, O_STALL, "lu3_bub3");
    step3(idle, O_NORM, "lu3_resume");
    chk("lu3_st3", 32'(st3), 32'd3);

    // Taken branch aborts a stall in progress.
    step3(haz, O_STALL, "abort_bub1");
    step3(tk, O_TAKEN, "abort_taken");
    step3(idle, O_NORM, "abort_resume");
    chk("abort_st", 32'(st3), 32'd4);
    chk("abort_fl", 32'(fl3), 32'd2);

    // Reset asserted in the second bubble cycle.
    step3(haz, O_STALL, "rstmid_bub1");
    @(negedge clk);
    in3 = idle;
    #1 chk("rstmid_bub2", 32'(o3), 32'(O_STALL));
    #1 rst3 = 1'b1;
    #1;
    chk("rstmid_out", 32'(o3), 32'(O_RST));
    chk("rstmid_st", 32'(st3), 32'd0);
    chk("rstmid_fl", 32'(fl3), 32'd0);
    @(negedge clk);
    rst3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step3(idle, O_NORM, $sformatf("rstmid_norm%0d", i));
    end
    chk("rstmid_st_after", 32'(st3), 32'd0);

    // Saturation: 2^16+2 consecutive stall cycles on the LU_STALLS=1 instance.
    @(negedge clk);
    in1 = haz;
    repeat (65538) @(posedge clk);
    @(negedge clk);
    chk("sat_st", 32'(st1), 32'h0000FFFF);
    chk("sat_out", 32'(o1), 32'(O_STALL));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat_hold", 32'(st1), 32'h0000FFFF);
    chk("sat_fl", 32'(fl1), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
